// File: rtl/seq_div_8by4.sv
// seq_div_8by4: sequential unsigned restoring divider.
//
// Divides a DW-bit dividend by a VW-bit divisor and produces one quotient
// bit per clock. The handshake is start/busy/done:
//   - start is sampled only while idle. The operands are captured on the
//     accepting edge and may change freely afterwards.
//   - busy is high for the DW cycles in which the division steps run.
//   - done pulses for one cycle. quotient, remainder and div0 are valid
//     in that cycle and hold until the next result or reset.
// A zero divisor skips the steps. The divider goes straight to the done
// cycle and returns quotient = all ones, remainder = 0 and div0 = 1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request pulse, sampled only when idle
//   dividend   DW-bit numerator, captured on acceptance
//   divisor    VW-bit denominator, captured on acceptance
//   quotient   DW-bit registered result
//   remainder  VW-bit registered result
//   busy       high while a division is in progress
//   done       one-cycle pulse when results are updated
//   div0       high when the last result came from a zero divisor
module seq_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div0
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] q_reg;   // dividend shifts out as quotient bits shift in
    logic [VW-1:0] d_reg;
    logic [VW-1:0] r_reg;   // partial remainder; always < divisor between steps
    logic [CW-1:0] count;

    // One restoring step. r_reg < d_reg holds between steps, so the shifted
    // remainder fits in VW+1 bits. The MSB of the trial difference is the
    // borrow, and a clear borrow means the subtraction is kept.
    logic [VW:0]   r_shift;
    logic [VW:0]   r_trial;
    logic [VW-1:0] r_next;
    logic [DW-1:0] q_next;

    always_comb begin
        r_shift = {r_reg, q_reg[DW-1]};
        r_trial = r_shift - {1'b0, d_reg};
        r_next  = r_shift[VW-1:0];
        q_next  = {q_reg[DW-2:0], 1'b0};
        if (!r_trial[VW]) begin
            r_next = r_trial[VW-1:0];
            q_next = {q_reg[DW-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div0      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            // Skip the steps; the results load right away.
                            state     <= S_DONE;
                            quotient  <= '1;
                            remainder <= '0;
                            div0      <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (count == CW'(DW - 1)) begin
                        // Last step: publish results so they are valid with done.
                        state     <= S_DONE;
                        quotient  <= q_next;
                        remainder <= r_next;
                        div0      <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here.
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
